// File: rtl/dff_2.sv
// dff_2: width-parameterisable D flip-flop with synchronous active-high reset.
// Drives the registered value and its bitwise complement from one register.
module dff_2 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  // Capture D every rising edge; reset wins over D.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= D;
    end
  end

  // Complement comes off the same register so it can never disagree with Q.
  assign Qbar = ~Q;

endmodule

// File: tb/tb_dff_2.sv
// tb_dff_2: directed vector table plus hand-written multi-cycle sequences.
// Checks the 1-bit default cell and a 4-bit cell with reset value 4'hA.
module tb_dff_2;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q;
  logic       qbar;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] qbar4;

  int tests;
  int fails;

  dff_2 u_dut (
    .CLK  (clk),
    .RESET(rst),
    .D    (d),
    .Q    (q),
    .Qbar (qbar)
  );

  dff_2 #(
    .WIDTH      (4),
    .RESET_VALUE(4'hA)
  ) u_dut4 (
    .CLK  (clk),
    .RESET(rst),
    .D    (d4),
    .Q    (q4),
    .Qbar (qbar4)
  );

  typedef struct {
    logic       rst;
    logic       d;
    logic [3:0] d4;
    logic       q;
    logic [3:0] q4;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic q_exp,
                           input logic [3:0] q4_exp);
    check({tag, " q"}, {3'b0, q}, {3'b0, q_exp});
    check({tag, " qbar"}, {3'b0, qbar}, {3'b0, ~q_exp});
    check({tag, " q4"}, q4, q4_exp);
    check({tag, " qbar4"}, qbar4, ~q4_exp);
  endtask

  // Rising edge, sample 1 ns later, then falling edge; ends with clk low.
  task automatic cycle_check(input string tag,
                             input logic q_exp,
                             input logic [3:0] q4_exp);
    #5 clk = 1'b1;
    #1 check_all(tag, q_exp, q4_exp);
    #4 clk = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk   = 1'b0;
    rst   = 1'b0;
    d     = 1'b0;
    d4    = 4'h0;

    vecs[0] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'hA};
    vecs[1] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[2] = '{1'b0, 1'b0, 4'h3, 1'b0, 4'h3};
    vecs[3] = '{1'b0, 1'b1, 4'hC, 1'b1, 4'hC};
    vecs[4] = '{1'b0, 1'b0, 4'h5, 1'b0, 4'h5};
    vecs[5] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'hA};
    vecs[6] = '{1'b0, 1'b1, 4'hF, 1'b1, 4'hF};
    vecs[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'hA};
    vecs[8] = '{1'b0, 1'b1, 4'h9, 1'b1, 4'h9};

    #2;
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      d   = vecs[i].d;
      d4  = vecs[i].d4;
      cycle_check($sformatf("vec%0d", i), vecs[i].q, vecs[i].q4);
    end

    // Q=1, Q4=9 here. Toggle D with clk low: no movement.
    d  = 1'b0;
    d4 = 4'h2;
    #2;
    d  = 1'b1;
    d4 = 4'h7;
    #2;
    d  = 1'b0;
    d4 = 4'h6;
    #1 check_all("toggle_no_edge", 1'b1, 4'h9);

    // Reset pulse of 10 ns with clk held low: no effect.
    rst = 1'b1;
    #10;
    check_all("rst_pulse_mid", 1'b1, 4'h9);
    rst = 1'b0;
    #2 check_all("rst_no_edge", 1'b1, 4'h9);

    // Falling-edge immunity: capture on rise, change D while high.
    d  = 1'b0;
    d4 = 4'h4;
    #3 clk = 1'b1;
    #1 check_all("rise_capture", 1'b0, 4'h4);
    d  = 1'b1;
    d4 = 4'hB;
    #2 clk = 1'b0;
    #1 check_all("fall_hold", 1'b0, 4'h4);
    #1;
    cycle_check("next_rise", 1'b1, 4'hB);

    // Reset asserted mid-stream only lands at the next edge.
    rst = 1'b1;
    d   = 1'b1;
    d4  = 4'hE;
    #2 check_all("rst_pending", 1'b1, 4'hB);
    cycle_check("rst_lands", 1'b0, 4'hA);
    rst = 1'b0;
    cycle_check("rst_release", 1'b1, 4'hE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
